// File: rtl/mem_sched_pkg.sv
// Shared types for the DRAM command scheduler: bus command encoding, bank state
// and the head-of-queue request layout.
package mem_sched_pkg;

    localparam int SCHED_NUM_BANKS = 8;
    localparam int SCHED_BANK_BITS = $clog2(SCHED_NUM_BANKS);
    localparam int SCHED_ROW_BITS  = 8;
    localparam int SCHED_COL_BITS  = 8;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        PRE = 3'd1,
        ACT = 3'd2,
        RD  = 3'd3,
        WR  = 3'd4
    } mem_cmd_e;

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        OPEN   = 2'd1,
        BUSY   = 2'd2
    } bank_state_e;

    typedef struct packed {
        logic [SCHED_BANK_BITS-1:0] bank;
        logic [SCHED_ROW_BITS-1:0]  row;
        logic [SCHED_COL_BITS-1:0]  col;
        logic                       write;
    } mem_sched_req_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_bank_tracker.sv
// One DRAM bank: open/closed flag, open row and a down-counting timing window.
// BUSY is reported whenever the timer is still running.
module mem_bank_tracker
    import mem_sched_pkg::*;
#(
    parameter int ROW_BITS = 8,
    parameter int T_RP     = 3,
    parameter int T_RCD    = 2,
    parameter int TMR_W    = $clog2(max2(T_RP, T_RCD) + 1)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                load,
    input  mem_cmd_e            cmd,
    input  logic [ROW_BITS-1:0] row,
    output bank_state_e         state,
    output logic [ROW_BITS-1:0] open_row,
    output logic                ready
);

    localparam logic [TMR_W-1:0] RP_LD  = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] RCD_LD = TMR_W'(T_RCD - 1);

    logic             is_open;
    logic [TMR_W-1:0] timer;

    // Column commands only issue with the timer at zero, so they fall through
    // to the (idle) decrement branch and leave the bank untouched.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            is_open  <= 1'b0;
            open_row <= '0;
            timer    <= '0;
        end else if (load && cmd == PRE) begin
            is_open <= 1'b0;
            timer   <= RP_LD;
        end else if (load && cmd == ACT) begin
            is_open  <= 1'b1;
            open_row <= row;
            timer    <= RCD_LD;
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign ready = (timer == '0);
    assign state = !ready ? BUSY : (is_open ? OPEN : CLOSED);

endmodule

// File: rtl/mem_bank_scheduler.sv
// Round-robin DRAM command scheduler over per-requester queue heads.
// Optional MEM_SCHED_ROW_HIT_FIRST_EN: favour eligible row hits before other commands.
module mem_bank_scheduler
    import mem_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_BANKS = 8,
    parameter int ROW_BITS  = 8,
    parameter int COL_BITS  = 8,
    parameter int T_RP      = 3,
    parameter int T_RCD     = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  mem_sched_req_t [NUM_REQ-1:0]  req_in,
    output logic [NUM_REQ-1:0]            req_pop_out,
    output logic                          cmd_valid_out,
    output mem_cmd_e                      cmd_out,
    output logic [$clog2(NUM_BANKS)-1:0]  cmd_bank_out,
    output logic [ROW_BITS-1:0]           cmd_row_out,
    output logic [COL_BITS-1:0]           cmd_col_out
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int TMR_W  = $clog2(max2(T_RP, T_RCD) + 1);

    bank_state_e [NUM_BANKS-1:0]               bank_state;
    logic        [NUM_BANKS-1:0][ROW_BITS-1:0] bank_row;
    logic        [NUM_BANKS-1:0]               bank_rdy;
    logic        [NUM_BANKS-1:0]               bank_load;

    mem_cmd_e [NUM_REQ-1:0] need_cmd;
    logic     [NUM_REQ-1:0] elig;
    logic     [NUM_REQ-1:0] hit;
    logic     [NUM_REQ-1:0] cand;

    logic           grant_vld;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W:0]   scan;
    mem_cmd_e       grant_cmd;
    mem_sched_req_t grant_req;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hit[i]  = (bank_state[req_in[i].bank] == OPEN) &&
                      (bank_row[req_in[i].bank] == req_in[i].row);
            elig[i] = req_valid_in[i] && bank_rdy[req_in[i].bank];
            if (bank_state[req_in[i].bank] == CLOSED)
                need_cmd[i] = ACT;
            else if (hit[i])
                need_cmd[i] = req_in[i].write ? WR : RD;
            else
                need_cmd[i] = PRE;
        end
    end

    always_comb begin
`ifdef MEM_SCHED_ROW_HIT_FIRST_EN
        cand = (|(elig & hit)) ? (elig & hit) : elig;
`else
        cand = elig;
`endif
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (scan >= (PTR_W + 1)'(NUM_REQ))
                scan = scan - (PTR_W + 1)'(NUM_REQ);
            if (!grant_vld && cand[scan[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan[PTR_W-1:0];
            end
        end
    end

    assign grant_cmd = grant_vld ? need_cmd[grant_idx] : NOP;
    assign grant_req = req_in[grant_idx];

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++)
            bank_load[b] = grant_vld && (grant_req.bank == BANK_W'(b));
    end

    // Pop is masked during reset so a stale decision never dequeues upstream.
    always_comb begin
        req_pop_out = '0;
        if (rst_in && (grant_cmd == RD || grant_cmd == WR))
            req_pop_out[grant_idx] = 1'b1;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank_tracker #(
            .ROW_BITS (ROW_BITS),
            .T_RP     (T_RP),
            .T_RCD    (T_RCD),
            .TMR_W    (TMR_W)
        ) u_trk (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .load     (bank_load[b]),
            .cmd      (grant_cmd),
            .row      (grant_req.row),
            .state    (bank_state[b]),
            .open_row (bank_row[b]),
            .ready    (bank_rdy[b])
        );
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr        <= '0;
            cmd_valid_out <= 1'b0;
            cmd_out       <= NOP;
            cmd_bank_out  <= '0;
            cmd_row_out   <= '0;
            cmd_col_out   <= '0;
        end else begin
            cmd_valid_out <= grant_vld;
            cmd_out       <= grant_cmd;
            if (grant_vld) begin
                rr_ptr       <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                cmd_bank_out <= grant_req.bank;
                cmd_row_out  <= grant_req.row;
                cmd_col_out  <= grant_req.col;
            end else begin
                cmd_bank_out <= '0;
                cmd_row_out  <= '0;
                cmd_col_out  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bank_scheduler.sv
// Directed scenarios plus randomized traffic against a timestamp-based bank model.
module tb_mem_bank_scheduler;
    import mem_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int NBANK = 8;
    localparam int T_RP  = 3;
    localparam int T_RCD = 2;

    logic                        clk_in = 1'b0;
    logic                        rst_in;
    logic [NREQ-1:0]             req_valid;
    mem_sched_req_t [NREQ-1:0]   req;
    logic [NREQ-1:0]             req_pop_out;
    logic                        cmd_valid_out;
    mem_cmd_e                    cmd_out;
    logic [2:0]                  cmd_bank_out;
    logic [7:0]                  cmd_row_out;
    logic [7:0]                  cmd_col_out;

    mem_bank_scheduler #(
        .NUM_REQ(NREQ), .NUM_BANKS(NBANK), .ROW_BITS(8), .COL_BITS(8),
        .T_RP(T_RP), .T_RCD(T_RCD)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid),
        .req_in        (req),
        .req_pop_out   (req_pop_out),
        .cmd_valid_out (cmd_valid_out),
        .cmd_out       (cmd_out),
        .cmd_bank_out  (cmd_bank_out),
        .cmd_row_out   (cmd_row_out),
        .cmd_col_out   (cmd_col_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Model: a bank becomes usable again at an absolute cycle number.
    bit         m_open  [NBANK];
    logic [7:0] m_row   [NBANK];
    int         m_ready [NBANK];
    int         m_rr;
    int         cyc = 0;

    logic [NREQ-1:0] obs_pop;
    logic            obs_valid;
    mem_cmd_e        obs_cmd;

    task automatic model_reset();
        for (int b = 0; b < NBANK; b++) begin
            m_open[b] = 0; m_row[b] = '0; m_ready[b] = 0;
        end
        m_rr = 0;
    endtask

    function automatic void model_decide(output int g, output mem_cmd_e gc);
        logic [NREQ-1:0] el, ht, cand;
        mem_cmd_e nd [NREQ];
        int b;
        for (int i = 0; i < NREQ; i++) begin
            b     = int'(req[i].bank);
            ht[i] = m_open[b] && (m_row[b] == req[i].row);
            el[i] = req_valid[i] && (cyc >= m_ready[b]);
            nd[i] = !m_open[b] ? ACT : (ht[i] ? (req[i].write ? WR : RD) : PRE);
        end
        cand = el;
`ifdef MEM_SCHED_ROW_HIT_FIRST_EN
        if (|(el & ht)) cand = el & ht;
`endif
        g = -1;
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && cand[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
        gc = (g >= 0) ? nd[g] : NOP;
    endfunction

    // One scheduling cycle: inputs were driven just after the previous edge.
    task automatic cycle();
        int g, b;
        mem_cmd_e gc;
        logic [NREQ-1:0] exp_pop;
        mem_sched_req_t r;
        #1;
        model_decide(g, gc);
        exp_pop = '0;
        if (g >= 0 && (gc == RD || gc == WR)) exp_pop[g] = 1'b1;
        obs_pop = req_pop_out;
        chk("pop", 32'(req_pop_out), 32'(exp_pop));
        r = (g >= 0) ? req[g] : '0;
        if (g >= 0) begin
            b = int'(r.bank);
            if (gc == PRE) begin m_open[b] = 0; m_ready[b] = cyc + T_RP; end
            if (gc == ACT) begin m_open[b] = 1; m_row[b] = r.row; m_ready[b] = cyc + T_RCD; end
            m_rr = (g + 1) % NREQ;
        end
        cyc++;
        @(posedge clk_in); #1;
        obs_valid = cmd_valid_out;
        obs_cmd   = cmd_out;
        chk("cmd_valid", 32'(cmd_valid_out), 32'(g >= 0));
        chk("cmd", 32'(cmd_out), 32'(gc));
        if (g >= 0) chk("cmd_bank", 32'(cmd_bank_out), 32'(r.bank));
        if (gc == ACT) chk("cmd_row", 32'(cmd_row_out), 32'(r.row));
        if (gc == RD || gc == WR) chk("cmd_col", 32'(cmd_col_out), 32'(r.col));
    endtask

    task automatic set_req(input int i, input int bank, input int row, input int col, input bit wr);
        req[i].bank  = 3'(bank);
        req[i].row   = 8'(row);
        req[i].col   = 8'(col);
        req[i].write = wr;
        req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
    endtask

    mem_cmd_e hist [8];
    int       pops, pop_at;

    initial begin
        req_valid = '0;
        req       = '0;
        do_reset();
        chk("rst_valid", 32'(cmd_valid_out), 32'd0);
        chk("rst_cmd",   32'(cmd_out), 32'(NOP));
        chk("rst_bank",  32'(cmd_bank_out), 32'd0);
        chk("rst_row",   32'(cmd_row_out), 32'd0);
        chk("rst_col",   32'(cmd_col_out), 32'd0);

        // Closed bank: ACT, wait T_RCD, RD with a single pop.
        set_req(0, 2, 8'h11, 8'h05, 1'b0);
        pops = 0; pop_at = -1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            hist[k] = obs_cmd;
            if (obs_pop[0]) begin pops++; pop_at = k; req_valid[0] = 1'b0; end
        end
        chk("s1_act", 32'(hist[0]), 32'(ACT));
        chk("s1_rd",  32'(hist[2]), 32'(RD));
        chk("s1_pops", 32'(pops), 32'd1);
        chk("s1_pop_at", 32'(pop_at), 32'd2);

        // Row miss: PRE, ACT after T_RP, WR after T_RCD.
        set_req(0, 2, 8'h22, 8'h07, 1'b1);
        pops = 0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            hist[k] = obs_cmd;
            if (obs_pop[0]) begin pops++; req_valid[0] = 1'b0; end
        end
        chk("s2_pre", 32'(hist[0]), 32'(PRE));
        chk("s2_act", 32'(hist[3]), 32'(ACT));
        chk("s2_wr",  32'(hist[5]), 32'(WR));
        chk("s2_pops", 32'(pops), 32'd1);

        // Three row hits served back to back in pointer order.
        do_reset();
        set_req(3, 0, 5, 0, 1'b0);
        cycle();
        req_valid[3] = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) set_req(i, 0, 5, i + 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("s3_grant", 32'(obs_pop), 32'(1 << k));
            req_valid = req_valid & ~obs_pop;
        end
        set_req(0, 0, 5, 9, 1'b0);
        set_req(3, 0, 5, 9, 1'b0);
        cycle();
        chk("s3_rr3", 32'(obs_pop), 32'h8);
        req_valid = req_valid & ~obs_pop;

        // Pointer at 0: req 0 needs ACT, req 1 is a row hit.
        req_valid = '0;
        set_req(0, 1, 7, 0, 1'b0);
        set_req(1, 0, 5, 3, 1'b0);
        cycle();
`ifdef MEM_SCHED_ROW_HIT_FIRST_EN
        chk("s4_first", 32'(obs_cmd), 32'(RD));
`else
        chk("s4_first", 32'(obs_cmd), 32'(ACT));
`endif
        req_valid = '0;
        repeat (4) cycle();

        // Both requesters blocked by bank 3's ACT window.
        set_req(2, 3, 9, 0, 1'b0);
        cycle();
        req_valid = '0;
        set_req(0, 3, 9, 1, 1'b0);
        set_req(1, 3, 9, 2, 1'b0);
        cycle();
        chk("s5_pop", 32'(obs_pop), 32'd0);
        chk("s5_valid", 32'(obs_valid), 32'd0);
        cycle();
        chk("s5_after", 32'(obs_valid), 32'd1);
        req_valid = '0;
        repeat (4) cycle();

        // Reset during a PRE window, then the old row must be re-activated.
        set_req(0, 3, 1, 0, 1'b0);
        cycle();
        chk("s6_pre", 32'(obs_cmd), 32'(PRE));
        rst_in = 1'b0;
        #1;
        chk("s6_valid", 32'(cmd_valid_out), 32'd0);
        chk("s6_cmd",   32'(cmd_out), 32'(NOP));
        chk("s6_bank",  32'(cmd_bank_out), 32'd0);
        chk("s6_pop",   32'(req_pop_out), 32'd0);
        model_reset();
        #1 rst_in = 1'b1;
        set_req(0, 3, 9, 0, 1'b0);
        cycle();
        chk("s6_act", 32'(obs_cmd), 32'(ACT));
        req_valid = '0;
        repeat (4) cycle();

        // Random traffic over a few banks and rows to provoke hits and conflicts.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (obs_pop[i] || $urandom_range(0, 7) == 0)
                    set_req(i, $urandom_range(0, 3), $urandom_range(1, 3),
                            $urandom_range(0, 255), 1'($urandom_range(0, 1)));
                req_valid[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bank_scheduler.md
# mem_bank_scheduler

Command scheduler between the per-requester memory command queues and the DRAM command bus. Each cycle it picks at most one requester by round-robin arbitration and decides which command that requester's head request needs: PRECHARGE, ACTIVATE, READ or WRITE. It tracks open-row state and timing per bank. A request is consumed only when its column command issues, so the pop pulse drives the upstream queue's dequeue.

## Interface
- NUM_REQ, 4 — number of requesters/queues (≥2).
- NUM_BANKS, 8 — flattened bank-group × bank count (power of 2).
- ROW_BITS, 8 — row address width.
- COL_BITS, 8 — column address width.
- T_RP, 3 — minimum cycles from PRE to ACT on the same bank (≥1).
- T_RCD, 2 — minimum cycles from ACT to RD/WR on the same bank (≥1).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset; one clock, asynchronous, active-low.
- req_valid_in  in  NUM_REQ  bit i: requester i head is valid (queue not empty).
- req_in  in  NUM_REQ × mem_sched_req_t  head requests; fields: bank, row, col, write.
- req_pop_out  out  NUM_REQ  one-hot combinational; bit i pops requester i at this clock edge.
- cmd_valid_out  out  1  registered; a command is on the bus this cycle.
- cmd_out  out  3  registered mem_cmd_e value.
- cmd_bank_out  out  $clog2(NUM_BANKS)  registered.
- cmd_row_out  out  ROW_BITS  registered; valid for ACT.
- cmd_col_out  out  COL_BITS  registered; valid for RD/WR.

## Operation
- Per-bank state is CLOSED, OPEN or BUSY, plus an open_row register and a down-counter timer.
- Command needed by a valid request to bank b, row r:
  - b CLOSED → ACT.
  - b OPEN and open_row==r → RD, or WR if write=1 (row hit).
  - b OPEN and open_row≠r → PRE.
- A requester is eligible iff its valid bit is high and the target bank timer is 0.
- Arbitration: the first eligible requester scanning from rr_ptr upward, modulo NUM_REQ, wins.
- After any grant, rr_ptr ← winner+1 (wraps).
- Command effects:
  - PRE: bank → CLOSED, timer ← T_RP−1.
  - ACT: bank → OPEN, open_row ← r, timer ← T_RCD−1.
  - RD/WR: req_pop_out[winner]=1, bank and timer unchanged.
- Nonzero timers decrement by 1 every cycle, saturating at 0.
- ACT and PRE never pop. The same request re-arbitrates until it reaches its column command.
- At most one command per cycle, so at most one bank changes state per cycle.
- No eligible requester → cmd_valid_out=0 next cycle, cmd_out=NOP, rr_ptr unchanged.
- Two requesters targeting one bank with different rows may alternate PRE/ACT. This is accepted behaviour; upstream ordering owns starvation avoidance.

## Timing
- Decision is combinational from inputs and state in cycle t.
- req_pop_out is asserted in cycle t.
- The command is registered and appears on cmd_* in cycle t+1.
- Same-bank spacing on cmd_valid_out: PRE→ACT exactly T_RP cycles when otherwise unblocked; ACT→RD/WR exactly T_RCD cycles.
- Different banks may issue on consecutive cycles.
- Reset values: cmd_valid_out=0, cmd_out=NOP, cmd_bank_out/cmd_row_out/cmd_col_out=0, all banks CLOSED, open_row=0, timers=0, rr_ptr=0.
- req_pop_out is 0 while rst_in=0.
- Reset asserted mid-operation clears everything immediately, with no drain. Afterwards every bank is CLOSED, so the first access to any bank issues ACT.
- Timer width is $clog2(max(T_RP,T_RCD)+1).

## Configuration
- MEM_SCHED_ROW_HIT_FIRST_EN:
  - Defined: two-level arbitration. Round-robin among eligible row-hit requesters first; round-robin among the rest only if no row hit is eligible. Uses the same rr_ptr.
  - Undefined: a single round-robin over all eligible requesters.

## Structure
- Package mem_sched_pkg holds:
  - mem_cmd_e: NOP=0, PRE=1, ACT=2, RD=3, WR=4.
  - bank_state_e.
  - mem_sched_req_t, parameterised via package localparams matching the defaults.
- Sub-module mem_bank_tracker holds one bank's state, open_row and timer. It is instantiated NUM_BANKS times.
- Each tracker takes a load strobe plus the command, and outputs state, open_row and ready.

## Test plan
Parameters: T_RP=3, T_RCD=2.
1. Reset, then req 0 = {bank 2, row 0x11, col 0x05, read} held valid → ACT b2 r0x11 on cycle 1, RD b2 c0x05 on cycle 3, req_pop_out[0] pulses once, in cycle 2.
2. Bank 2 open at row 0x11; req 0 = {bank 2, row 0x22, write} → PRE at cycle 1, ACT r0x22 at cycle 4, WR at cycle 6, single pop.
3. Bank 0 open at row 5; reqs 0, 1, 2 all row hits, rr_ptr=0 → RD grants to 0, 1, 2 on consecutive cycles, then rr_ptr=3.
4. rr_ptr=0; req 0 needs ACT on bank 1, req 1 is a row hit on bank 0 → with the macro, RD for req 1 issues first; without it, ACT for req 0 issues first.
5. Reqs 0 and 1 both target bank 3 during its T_RCD window; no other requests → cmd_valid_out=0 and req_pop_out=0 until the timer reaches 0.
6. Assert rst_in low while a PRE timer is at 2 → all outputs take their reset values immediately. After release, a request to the previously open row issues ACT, not RD.
